load_store_unit: RTL and testbench

Memory-stage load/store unit that sits directly upstream of the data RAM. It accepts one load or store per cycle from execute and drives the RAM's `addr`/`w_data`/`w_width`/`w_enable` port. It consumes the RAM's 1-cycle-latency, offset-shifted `r_data`, then sign- or zero-extends it into a registered writeback response. Accesses that cross a word boundary are split into multiple RAM accesses, because the RAM returns zeroes for the upper bytes of such accesses.

---
 rtl/load_store_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// lsu_pkg / load_store_unit
//
// Memory-stage load/store unit placed directly in front of the data RAM.
// Accepts one load or store per cycle, drives the RAM address/write port
// and turns the RAM's 1-cycle-latency, offset-shifted read data into a
// sign/zero-extended, registered writeback response.
//
// The RAM truncates any access at the word boundary, so accesses that
// cross a word are split: the low part issues with the original request,
// then one (load, or store with 1-2 high bytes) or two (store with 3 high
// bytes) follow-up accesses cover the next word.
//
// Ports
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   req_*                 request from execute (valid/ready handshake)
//   mem_addr/w_data/
//   w_width/w_enable      RAM port, driven combinationally in IDLE
//   mem_r_data            RAM read data, one cycle after the address
//   resp_valid/rd/data    one-cycle load writeback pulse, no back-pressure
//   fault                 one-cycle pulse for a rejected word-crossing access
// ---------------------------------------------------------------------------
package lsu_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WIDTH_BYTE     = 2'd0,
        WIDTH_HALFWORD = 2'd1,
        WIDTH_WORD     = 2'd2
    } mem_width_t;
endpackage

module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_store,
    input  mem_width_t       req_width,
    input  logic             req_unsigned,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_w_data,
    input  logic [4:0]       req_rd,

    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_w_data,
    output mem_width_t       mem_w_width,
    output logic             mem_w_enable,
    input  logic [XLEN-1:0]  mem_r_data,

    output logic             resp_valid,
    output logic [4:0]       resp_rd,
    output logic [XLEN-1:0]  resp_data,
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI0  = 2'd1,
        HI1  = 2'd2
    } state_t;

    function automatic logic [2:0] size_of(input mem_width_t w);
        case (w)
            WIDTH_BYTE:     return 3'd1;
            WIDTH_HALFWORD: return 3'd2;
            default:        return 3'd4;
        endcase
    endfunction

    state_t            r_state;

    // Latched split request
    logic [XLEN-3:0]   r_word;       // word index of the low part
    logic [XLEN-1:0]   r_data;
    logic              r_is_store;
    mem_width_t        r_width;
    logic              r_unsigned;
    logic [4:0]        r_rd;
    logic [2:0]        r_n;          // bytes in the low part
    logic [2:0]        r_m;          // bytes in the high part

    // Load data stage: valid while the final RAM read data is on mem_r_data
    logic              r_s1_vld;
    logic [4:0]        r_s1_rd;
    mem_width_t        r_s1_width;
    logic              r_s1_uns;
    logic [2:0]        r_s1_n;       // byte position of the high data (0 if not split)
    logic [XLEN-1:0]   r_low;        // captured low part of a split load

    logic [2:0]        w_size;
    logic [1:0]        w_off;
    logic [2:0]        w_n;
    logic              w_cross;
    logic              w_bad;
    logic              w_accept;
    logic [XLEN-1:0]   w_next_word;
    logic [XLEN-1:0]   w_low_mask;
    logic [XLEN-1:0]   w_merged;
    logic [XLEN-1:0]   w_ext;

    assign w_size      = size_of(req_width);
    assign w_off       = req_addr[1:0];
    assign w_n         = 3'd4 - {1'b0, w_off};
    assign w_cross     = ({2'b00, w_off} + {1'b0, w_size}) > 4'd4;
    assign w_bad       = w_cross & ~ALLOW_MISALIGNED;
    assign req_ready   = reset_n & (r_state == IDLE);
    assign w_accept    = req_valid & req_ready;
    assign w_next_word = {r_word + 1'b1, 2'b00};
    assign w_low_mask  = (XLEN'(1) << {r_n, 3'b000}) - XLEN'(1);

    // RAM port: pass-through in IDLE, high-part accesses from the latch otherwise
    always_comb begin
        mem_addr     = req_addr;
        mem_w_data   = req_w_data;
        mem_w_width  = req_width;
        mem_w_enable = req_valid & req_is_store & ~w_bad;
        case (r_state)
            HI0: begin
                mem_addr     = w_next_word;
                mem_w_data   = r_data >> {r_n, 3'b000};
                mem_w_width  = !r_is_store ? WIDTH_WORD :
                               (r_m == 3'd1) ? WIDTH_BYTE : WIDTH_HALFWORD;
                mem_w_enable = r_is_store;
            end
            HI1: begin
                // Third high byte of a word store with one low byte
                mem_addr     = w_next_word + XLEN'(2);
                mem_w_data   = r_data >> ({r_n, 3'b000} + 6'd16);
                mem_w_width  = WIDTH_BYTE;
                mem_w_enable = 1'b1;
            end
            default: ;
        endcase
        if (!reset_n) mem_w_enable = 1'b0;
    end

    // Merge split halves, then truncate to the access size and extend
    always_comb begin
        w_merged = r_low | (mem_r_data << {r_s1_n, 3'b000});
        case (r_s1_width)
            WIDTH_BYTE:     w_ext = {{(XLEN-8){w_merged[7] & ~r_s1_uns}}, w_merged[7:0]};
            WIDTH_HALFWORD: w_ext = {{(XLEN-16){w_merged[15] & ~r_s1_uns}}, w_merged[15:0]};
            default:        w_ext = w_merged;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_data     <= '0;
            r_is_store <= 1'b0;
            r_width    <= WIDTH_BYTE;
            r_unsigned <= 1'b0;
            r_rd       <= '0;
            r_n        <= '0;
            r_m        <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_rd    <= '0;
            r_s1_width <= WIDTH_BYTE;
            r_s1_uns   <= 1'b0;
            r_s1_n     <= '0;
            r_low      <= '0;
            resp_valid <= 1'b0;
            resp_rd    <= '0;
            resp_data  <= '0;
            fault      <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            r_s1_vld   <= 1'b0;

            if (r_s1_vld) begin
                resp_valid <= 1'b1;
                resp_rd    <= r_s1_rd;
                resp_data  <= w_ext;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_bad) begin
                            fault <= 1'b1;
                        end else if (w_cross) begin
                            r_state    <= HI0;
                            r_word     <= req_addr[XLEN-1:2];
                            r_data     <= req_w_data;
                            r_is_store <= req_is_store;
                            r_width    <= req_width;
                            r_unsigned <= req_unsigned;
                            r_rd       <= req_rd;
                            r_n        <= w_n;
                            r_m        <= w_size - w_n;
                        end else if (!req_is_store) begin
                            r_s1_vld   <= 1'b1;
                            r_s1_rd    <= req_rd;
                            r_s1_width <= req_width;
                            r_s1_uns   <= req_unsigned;
                            r_s1_n     <= 3'd0;
                            r_low      <= '0;
                        end
                    end
                end
                HI0: begin
                    if (r_is_store) begin
                        r_state <= (r_m == 3'd3) ? HI1 : IDLE;
                    end else begin
                        // Low-part read data is on mem_r_data this cycle
                        r_state    <= IDLE;
                        r_s1_vld   <= 1'b1;
                        r_s1_rd    <= r_rd;
                        r_s1_width <= r_width;
                        r_s1_uns   <= r_unsigned;
                        r_s1_n     <= r_n;
                        r_low      <= mem_r_data & w_low_mask;
                    end
                end
                HI1:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // DUT with split support
    logic        req_valid, req_is_store, req_unsigned, req_ready;
    mem_width_t  req_width;
    logic [31:0] req_addr, req_w_data;
    logic [4:0]  req_rd;
    logic [31:0] mem_addr, mem_w_data, mem_r_data;
    mem_width_t  mem_w_width;
    logic        mem_w_enable;
    logic        resp_valid, fault;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;

    // DUT with misaligned accesses rejected
    logic        f_req_valid, f_req_is_store, f_req_unsigned, f_req_ready;
    mem_width_t  f_req_width;
    logic [31:0] f_req_addr, f_req_w_data;
    logic [4:0]  f_req_rd;
    logic [31:0] f_mem_addr, f_mem_w_data;
    logic [31:0] f_mem_r_data = 32'h0;
    mem_width_t  f_mem_w_width;
    logic        f_mem_w_enable;
    logic        f_resp_valid, f_fault;
    logic [4:0]  f_resp_rd;
    logic [31:0] f_resp_data;

    load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_w_data(req_w_data), .req_rd(req_rd),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_width(mem_w_width),
        .mem_w_enable(mem_w_enable), .mem_r_data(mem_r_data),
        .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data), .fault(fault)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_nomis (
        .clock(clock), .reset_n(reset_n),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_is_store(f_req_is_store),
        .req_width(f_req_width), .req_unsigned(f_req_unsigned), .req_addr(f_req_addr),
        .req_w_data(f_req_w_data), .req_rd(f_req_rd),
        .mem_addr(f_mem_addr), .mem_w_data(f_mem_w_data), .mem_w_width(f_mem_w_width),
        .mem_w_enable(f_mem_w_enable), .mem_r_data(f_mem_r_data),
        .resp_valid(f_resp_valid), .resp_rd(f_resp_rd), .resp_data(f_resp_data), .fault(f_fault)
    );

    function automatic int wsz(input mem_width_t w);
        return (w == WIDTH_BYTE) ? 1 : (w == WIDTH_HALFWORD) ? 2 : 4;
    endfunction

    // Data RAM: byte enables stop at the word boundary, reads shifted by addr[1:0]
    logic [7:0]  ram [0:255];
    logic        ram_clr;
    logic [31:0] ram_rd;
    always_comb begin
        ram_rd = '0;
        for (int i = 0; i < 4; i++)
            if (int'(mem_addr[1:0]) + i < 4)
                ram_rd[8*i +: 8] = ram[int'(mem_addr[7:0]) + i];
    end
    always @(posedge clock) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (mem_w_enable) begin
            for (int i = 0; i < wsz(mem_w_width); i++)
                if (int'(mem_addr[1:0]) + i < 4)
                    ram[int'(mem_addr[7:0]) + i] <= mem_w_data[8*i +: 8];
        end
        mem_r_data <= ram_rd;
    end

    // Reference model: flat byte memory, accesses are just byte runs
    logic [7:0] ref_mem [0:255];

    typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } exp_t;
    exp_t expq[$];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Response monitor: every response must match the queue head in the expected cycle
    always @(negedge clock) begin
        if (resp_valid) begin
            if (expq.size() == 0 || expq[0].cyc != cyc) begin
                n_vec++; n_err++;
                $display("FAIL resp_spurious cyc=%0d got=%h", cyc, resp_data);
            end else begin
                chk("resp_data", resp_data, expq[0].data);
                chk("resp_rd", {27'h0, resp_rd}, {27'h0, expq[0].rd});
                void'(expq.pop_front());
            end
        end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
            n_vec++; n_err++;
            $display("FAIL resp_missing cyc=%0d got=none exp=%h", cyc, expq[0].data);
            void'(expq.pop_front());
        end
    end

    // Issue one request (called just after a rising edge), walk its busy cycles
    task automatic issue(input bit st, input mem_width_t w, input bit uns,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input bit use_exp, input logic [31:0] exp_d);
        int s, o, m, busy, t;
        logic [31:0] v;
        s = wsz(w); o = int'(a[1:0]); m = s - (4 - o);
        busy = (o + s > 4) ? ((st && m == 3) ? 2 : 1) : 0;
        v = '0;
        if (st) begin
            for (int i = 0; i < s; i++) ref_mem[(int'(a) + i) & 255] = d[8*i +: 8];
        end else begin
            for (int i = 0; i < s; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) & 255];
            if (!uns && s < 4 && v[8*s-1])
                for (int i = s; i < 4; i++) v[8*i +: 8] = 8'hFF;
            if (use_exp) v = exp_d;
        end
        t = cyc;
        req_valid = 1'b1; req_is_store = st; req_width = w; req_unsigned = uns;
        req_addr = a; req_w_data = d; req_rd = rd;
        if (!st) expq.push_back('{t + (busy > 0 ? 3 : 2), rd, v});
        @(negedge clock);
        chk("ready_issue", {31'h0, req_ready}, 32'h1);
        chk("addr_issue", mem_addr, a);
        chk("wen_issue", {31'h0, mem_w_enable}, {31'h0, st});
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int b = 0; b < busy; b++) begin
            @(negedge clock);
            chk("ready_busy", {31'h0, req_ready}, 32'h0);
            chk("addr_hi", mem_addr, {a[31:2], 2'b00} + 32'd4 + 32'(2 * b));
            chk("wen_hi", {31'h0, mem_w_enable}, {31'h0, st});
            @(posedge clock); #1;
        end
    endtask

    typedef struct { bit st; mem_width_t w; bit uns; logic [31:0] a; logic [31:0] d; logic [31:0] exp; } vec_t;
    vec_t tbl [15];

    initial begin
        tbl[0]  = '{1'b1, WIDTH_WORD,     1'b0, 32'h80, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, WIDTH_WORD,     1'b0, 32'h84, 32'h11223344, 32'h0};
        tbl[2]  = '{1'b0, WIDTH_WORD,     1'b0, 32'h80, 32'h0, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, WIDTH_BYTE,     1'b0, 32'h83, 32'h0, 32'hFFFFFFDE};
        tbl[4]  = '{1'b0, WIDTH_BYTE,     1'b1, 32'h83, 32'h0, 32'h000000DE};
        tbl[5]  = '{1'b0, WIDTH_HALFWORD, 1'b0, 32'h82, 32'h0, 32'hFFFFDEAD};
        tbl[6]  = '{1'b0, WIDTH_HALFWORD, 1'b1, 32'h81, 32'h0, 32'h0000ADBE};
        tbl[7]  = '{1'b0, WIDTH_WORD,     1'b0, 32'h83, 32'h0, 32'h223344DE};
        tbl[8]  = '{1'b1, WIDTH_WORD,     1'b0, 32'h84, 32'h0, 32'h0};
        tbl[9]  = '{1'b1, WIDTH_WORD,     1'b0, 32'h88, 32'h0, 32'h0};
        tbl[10] = '{1'b1, WIDTH_WORD,     1'b0, 32'h87, 32'hA1B2C3D4, 32'h0};
        tbl[11] = '{1'b0, WIDTH_WORD,     1'b0, 32'h84, 32'h0, 32'hD4000000};
        tbl[12] = '{1'b0, WIDTH_WORD,     1'b0, 32'h88, 32'h0, 32'h00A1B2C3};
        tbl[13] = '{1'b0, WIDTH_BYTE,     1'b0, 32'h8A, 32'h0, 32'hFFFFFFA1};
        tbl[14] = '{1'b0, WIDTH_HALFWORD, 1'b1, 32'h86, 32'h0, 32'h0000D400};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ram_clr = 1'b1;
        req_valid = 1'b1; req_is_store = 1'b1; req_width = WIDTH_WORD; req_unsigned = 1'b0;
        req_addr = 32'h40; req_w_data = 32'h12345678; req_rd = 5'd0;
        f_req_valid = 1'b0; f_req_is_store = 1'b0; f_req_width = WIDTH_WORD; f_req_unsigned = 1'b0;
        f_req_addr = 32'h0; f_req_w_data = 32'h0; f_req_rd = 5'd0;

        // Reset state, with a store held on the request port
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_wen", {31'h0, mem_w_enable}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_resp_rd", {27'h0, resp_rd}, 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1; ram_clr = 1'b0; req_valid = 1'b0;

        // Directed table, back to back
        for (int i = 0; i < 15; i++)
            issue(tbl[i].st, tbl[i].w, tbl[i].uns, tbl[i].a, tbl[i].d, 5'(i + 1), 1'b1, tbl[i].exp);
        repeat (4) begin @(posedge clock); #1; end

        // Reset during HI0 of a split load: no response, then an aligned load works
        req_valid = 1'b1; req_is_store = 1'b0; req_width = WIDTH_WORD; req_addr = 32'h83; req_rd = 5'd7;
        @(negedge clock);
        chk("mid_ready_issue", {31'h0, req_ready}, 32'h1);
        @(posedge clock); #1;
        req_valid = 1'b0; reset_n = 1'b0;
        @(negedge clock);
        chk("mid_ready_rst", {31'h0, req_ready}, 32'h0);
        chk("mid_wen_rst", {31'h0, mem_w_enable}, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("mid_ready_idle", {31'h0, req_ready}, 32'h1);
        chk("mid_no_resp0", {31'h0, resp_valid}, 32'h0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_no_resp1", {31'h0, resp_valid}, 32'h0);
        @(posedge clock); #1;
        issue(1'b0, WIDTH_WORD, 1'b0, 32'h80, 32'h0, 5'd9, 1'b0, 32'h0);

        // Reset during HI0 of a split halfword store: only the low byte lands
        req_valid = 1'b1; req_is_store = 1'b1; req_width = WIDTH_HALFWORD; req_addr = 32'h8F; req_w_data = 32'h5566;
        @(negedge clock);
        chk("mid_st_wen", {31'h0, mem_w_enable}, 32'h1);
        @(posedge clock); #1;
        req_valid = 1'b0; reset_n = 1'b0;
        @(negedge clock);
        chk("mid_st_wen_rst", {31'h0, mem_w_enable}, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        ref_mem[8'h8F] = 8'h66;
        issue(1'b0, WIDTH_WORD, 1'b0, 32'h8C, 32'h0, 5'd10, 1'b0, 32'h0);
        issue(1'b0, WIDTH_WORD, 1'b0, 32'h90, 32'h0, 5'd11, 1'b0, 32'h0);
        repeat (4) begin @(posedge clock); #1; end

        // Misaligned accesses rejected
        f_req_valid = 1'b1; f_req_is_store = 1'b0; f_req_width = WIDTH_WORD; f_req_addr = 32'h82;
        @(negedge clock);
        chk("nm_lw_ready", {31'h0, f_req_ready}, 32'h1);
        chk("nm_lw_wen", {31'h0, f_mem_w_enable}, 32'h0);
        chk("nm_lw_fault0", {31'h0, f_fault}, 32'h0);
        @(posedge clock); #1; f_req_valid = 1'b0;
        @(negedge clock);
        chk("nm_lw_fault1", {31'h0, f_fault}, 32'h1);
        chk("nm_lw_resp1", {31'h0, f_resp_valid}, 32'h0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("nm_lw_fault2", {31'h0, f_fault}, 32'h0);
        chk("nm_lw_resp2", {31'h0, f_resp_valid}, 32'h0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("nm_lw_resp3", {31'h0, f_resp_valid}, 32'h0);
        @(posedge clock); #1;
        f_req_valid = 1'b1; f_req_is_store = 1'b1; f_req_width = WIDTH_HALFWORD;
        f_req_addr = 32'h83; f_req_w_data = 32'hBEEF;
        @(negedge clock);
        chk("nm_sh_wen", {31'h0, f_mem_w_enable}, 32'h0);
        @(posedge clock); #1; f_req_valid = 1'b0;
        @(negedge clock);
        chk("nm_sh_fault", {31'h0, f_fault}, 32'h1);
        chk("nm_sh_wen_after", {31'h0, f_mem_w_enable}, 32'h0);
        @(posedge clock); #1;
        f_req_valid = 1'b1; f_req_is_store = 1'b1; f_req_width = WIDTH_WORD; f_req_addr = 32'h80;
        @(negedge clock);
        chk("nm_sw_aligned_wen", {31'h0, f_mem_w_enable}, 32'h1);
        @(posedge clock); #1; f_req_valid = 1'b0;
        @(negedge clock);
        chk("nm_sw_aligned_fault", {31'h0, f_fault}, 32'h0);
        @(posedge clock); #1;

        // Randomized traffic against the byte-memory model
        for (int k = 0; k < 250; k++) begin
            logic        st;
            mem_width_t  w;
            st = ($urandom_range(0, 2) == 0);
            w  = mem_width_t'($urandom_range(0, 2));
            issue(st, w, 1'($urandom_range(0, 1)), 32'($urandom_range(32'h40, 32'hEF)),
                  $urandom, 5'($urandom_range(0, 31)), 1'b0, 32'h0);
            if ($urandom_range(0, 4) == 0) begin @(posedge clock); #1; end
        end

        repeat (5) begin @(posedge clock); #1; end
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
